// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, receiver alignment states and
// the combinational symbol decoder used by the receive-side stages.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } t_rx_state;

    // Returns {is_ctrl, ctrl[1:0], data[7:0]}; data is 0 for tokens and ctrl is 0 for data symbols.
    function automatic logic [10:0] tmds_decode(input logic [9:0] sym);
        logic [9:0]  q;
        logic [7:0]  d;
        logic [10:0] r;
        q = sym;
        if (q[9]) begin
            q[7:0] = ~q[7:0];
        end
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        case (sym)
            TOK_C00: r = {1'b1, 2'b00, 8'h00};
            TOK_C01: r = {1'b1, 2'b01, 8'h00};
            TOK_C10: r = {1'b1, 2'b10, 8'h00};
            TOK_C11: r = {1'b1, 2'b11, 8'h00};
            default: r = {1'b0, 2'b00, d};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_sym_stage.sv
// Registered classify/decode stage for one 10-bit TMDS symbol.
module tmds_sym_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [10:0] dec;

    assign dec = tmds_decode(sym_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            is_ctrl <= 1'b0;
            ctrl    <= 2'b00;
            data    <= 8'h00;
        end else begin
            is_ctrl <= dec[10];
            ctrl    <= dec[9:8];
            data    <= dec[7:0];
        end
    end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: word alignment via deserializer bit-slip, lock on runs
// of control tokens, and a two-stage decode pipeline gated by lock.
module tmds_rx_decoder
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN = 16,
    parameter int WINDOW    = 4096,
    parameter int SLIP_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    output logic [7:0] data,
    output logic       de,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic       bitslip,
    output logic [3:0] slip_pos,
    output t_rx_state  state
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
    localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(TOKEN_RUN);
    localparam logic [RUN_W-1:0]  RUN_PRE   = RUN_W'(TOKEN_RUN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    logic              s1_is_ctrl;
    logic [1:0]        s1_ctrl;
    logic [7:0]        s1_data;
    t_rx_state         state_nxt;
    logic [RUN_W-1:0]  run_cnt;
    logic              run_done;
    logic [WIN_W-1:0]  win_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    tmds_sym_stage u_sym_stage (
        .clk     (clk),
        .rst     (rst),
        .sym_in  (sym_in),
        .is_ctrl (s1_is_ctrl),
        .ctrl    (s1_ctrl),
        .data    (s1_data)
    );

    // run_done is a one-cycle pulse on the transition to a full run; a saturated
    // run does not re-fire until a data symbol breaks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt  <= '0;
            run_done <= 1'b0;
        end else if (state == WAIT || !s1_is_ctrl) begin
            run_cnt  <= '0;
            run_done <= 1'b0;
        end else if (run_cnt != RUN_FULL) begin
            run_cnt  <= run_cnt + 1'b1;
            run_done <= (run_cnt == RUN_PRE);
        end else begin
            run_done <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (run_done) begin
                    state_nxt = LOCKED;
                end else if (win_cnt == WIN_LAST) begin
                    state_nxt = SLIP;
                end
            end
            SLIP:   state_nxt = WAIT;
            WAIT:   if (wait_cnt == WAIT_LAST) state_nxt = SEARCH;
            LOCKED: if (!run_done && win_cnt == WIN_LAST) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_nxt != state || run_done) begin
            win_cnt <= '0;
        end else if (state == SEARCH || state == LOCKED) begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slip_pos <= 4'd0;
        end else if (state == SLIP) begin
            slip_pos <= (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
        end
    end

    assign locked  = (state == LOCKED);
    assign bitslip = (state == SLIP);

    // Gating on the next state keeps the registered outputs in step with locked.
    always_ff @(posedge clk) begin
        if (rst || state_nxt != LOCKED) begin
            data <= 8'h00;
            de   <= 1'b0;
            ctrl <= 2'b00;
        end else if (s1_is_ctrl) begin
            data <= 8'h00;
            de   <= 1'b0;
            ctrl <= s1_ctrl;
        end else begin
            data <= s1_data;
            de   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: lock, decode, slip alignment with a
// rotating-deserializer model, loss of lock, and mid-operation reset.
module tb_tmds_rx_decoder;
    import tmds_pkg::*;

    localparam int SLIP_PERIOD = 4096 + 8 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sym_in = 10'h000;
    logic [7:0] data;
    logic       de;
    logic [1:0] ctrl;
    logic       locked;
    logic       bitslip;
    logic [3:0] slip_pos;
    t_rx_state  state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    tmds_rx_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .sym_in   (sym_in),
        .data     (data),
        .de       (de),
        .ctrl     (ctrl),
        .locked   (locked),
        .bitslip  (bitslip),
        .slip_pos (slip_pos),
        .state    (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: present a symbol, then sample 1ns after the edge
    task automatic tick(input logic [9:0] s);
        sym_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_data(input string tag);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        check({tag, "_de"}, 32'(de), 1);
        check({tag, "_data"}, 32'(data), 32'(exp));
        check({tag, "_ctrl_hold"}, 32'(ctrl), 2);
    endtask

    function automatic logic [9:0] rotl10(input logic [9:0] v, input int r);
        logic [9:0] res;
        res = '0;
        for (int i = 0; i < 10; i++) begin
            res[(i + r) % 10] = v[i];
        end
        return res;
    endfunction

    // Deserializer model: tokens arrive rotated by 'off'; each bitslip pulse
    // removes one bit of rotation. No tokens at all until idle_slips pulses.
    task automatic align_run(input string tag, input int off0, input int idle_slips,
                             input int budget, output int pulses);
        int off;
        int last_t;
        logic prev_slip;
        off = off0;
        pulses = 0;
        last_t = -1;
        prev_slip = 1'b0;
        for (int t = 0; t < budget && !locked; t++) begin
            tick((pulses < idle_slips) ? 10'h100 : rotl10(TOK_C00, off));
            if (prev_slip) check({tag, "_slip_pos"}, 32'(slip_pos), 32'(pulses % 10));
            if (bitslip) begin
                check({tag, "_slip_state"}, 32'(state), 32'(SLIP));
                if (last_t >= 0) check({tag, "_gap"}, 32'(t - last_t), SLIP_PERIOD);
                last_t = t;
                pulses++;
                off = (off + 9) % 10;
            end
            prev_slip = bitslip;
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic seen;

        // reset
        rst = 1'b1;
        tick(10'h000);
        tick(10'h000);
        check("rst_locked", 32'(locked), 0);
        check("rst_bitslip", 32'(bitslip), 0);
        check("rst_slip_pos", 32'(slip_pos), 0);
        check("rst_de", 32'(de), 0);
        check("rst_data", 32'(data), 0);
        check("rst_ctrl", 32'(ctrl), 0);
        check("rst_state", 32'(state), 32'(SEARCH));
        rst = 1'b0;

        // 16 aligned blanking tokens -> run complete, then lock the cycle after
        repeat (16) tick(TOK_C00);
        tick(TOK_C00);
        check("lock_pending", 32'(locked), 0);
        tick(TOK_C00);
        check("lock_up", 32'(locked), 1);
        check("lock_state", 32'(state), 32'(LOCKED));
        tick(TOK_C01);
        check("tok00_ctrl", 32'(ctrl), 0);
        check("tok00_de", 32'(de), 0);
        tick(TOK_C10);
        check("tok01_ctrl", 32'(ctrl), 1);

        // data decode; ctrl keeps the last token code (10)
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        tick(10'h100);
        check("tok10_ctrl", 32'(ctrl), 2);
        tick(10'h1FF);
        check_data("d100");
        tick(10'h2FF);
        check_data("d1ff");
        tick(TOK_C01);
        check_data("d2ff");
        tick(TOK_C01);
        check("tok_after_data_de", 32'(de), 0);
        check("tok_after_data_data", 32'(data), 0);
        check("tok_after_data_ctrl", 32'(ctrl), 1);

        // fresh run restarts the window; then only data until lock drops:
        // window clears 2 ticks after the last token, counts 0..4095, drops one edge later
        tick(10'h100);
        repeat (16) tick(TOK_C00);
        n = 0;
        seen = 1'b0;
        while (locked && n < 5000) begin
            tick(10'h100);
            n++;
            seen = seen | bitslip;
        end
        check("loss_cycles", 32'(n), 4098);
        check("loss_no_slip", 32'(seen), 0);
        check("loss_state", 32'(state), 32'(SEARCH));
        check("loss_de", 32'(de), 0);
        check("loss_data", 32'(data), 0);

        // relock on 0x2AB
        repeat (16) tick(TOK_C11);
        tick(TOK_C11);
        check("relock_pending", 32'(locked), 0);
        tick(TOK_C11);
        check("relock_up", 32'(locked), 1);
        tick(TOK_C11);
        check("relock_ctrl", 32'(ctrl), 3);
        check("relock_de", 32'(de), 0);

        // stream rotated by 3 bits -> three slips, then lock
        rst = 1'b1;
        tick(10'h000);
        tick(10'h000);
        rst = 1'b0;
        align_run("rot3", 3, 0, 5 * SLIP_PERIOD, pulses);
        check("rot3_locked", 32'(locked), 1);
        check("rot3_pulses", 32'(pulses), 3);
        check("rot3_slip_pos", 32'(slip_pos), 3);

        // reset for one cycle in the middle of WAIT
        rst = 1'b1;
        tick(10'h000);
        rst = 1'b0;
        n = 0;
        while (!bitslip && n < 5000) begin
            tick(10'h100);
            n++;
        end
        check("wait_rst_pulse", 32'(bitslip), 1);
        tick(10'h100);
        tick(10'h100);
        tick(10'h100);
        check("wait_rst_pre_state", 32'(state), 32'(WAIT));
        check("wait_rst_pre_pos", 32'(slip_pos), 1);
        rst = 1'b1;
        tick(10'h100);
        rst = 1'b0;
        check("wait_rst_state", 32'(state), 32'(SEARCH));
        check("wait_rst_pos", 32'(slip_pos), 0);
        check("wait_rst_locked", 32'(locked), 0);
        check("wait_rst_bitslip", 32'(bitslip), 0);
        check("wait_rst_outs", 32'({de, ctrl, data}), 0);

        // 15 tokens then a data symbol is one short of a run
        repeat (15) tick(TOK_C00);
        tick(10'h100);
        seen = 1'b0;
        repeat (20) begin
            tick(10'h100);
            seen = seen | locked;
        end
        check("short_run_no_lock", 32'(seen), 0);
        check("short_run_state", 32'(state), 32'(SEARCH));

        // ten slips with an idle link (slip_pos wraps), then tokens 2 bits off
        rst = 1'b1;
        tick(10'h000);
        tick(10'h000);
        rst = 1'b0;
        align_run("wrap", 2, 10, 13 * SLIP_PERIOD, pulses);
        check("wrap_locked", 32'(locked), 1);
        check("wrap_pulses", 32'(pulses), 12);
        check("wrap_slip_pos", 32'(slip_pos), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
